// File: rtl/decouple_pkg.sv
// Shared helpers for the decouple FIFO: parameter legality checks.
package decouple_pkg;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Smallest legal storage depth.
  localparam int unsigned MIN_DEPTH = 2;

endpackage

// File: rtl/decouple_mem.sv
// DEPTH x DIN register array: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module decouple_mem #(
  parameter int DIN    = 8,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DIN-1:0]    wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DIN-1:0]    rdata
);

  logic [DIN-1:0] mem [DEPTH];

  // Store the incoming word on a write strobe; data storage carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/decouple.sv
// Valid/ready decoupling FIFO with first-word-fall-through output.
// din_ready is decoded only from registered pointers (and rst), so the
// downstream ready path is cut here.
module decouple
  import decouple_pkg::*;
#(
  parameter int DIN   = 0,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  output logic           din_ready,
  input  logic           din_valid,
  input  logic [DIN-1:0] din_data,
  input  logic           dout_ready,
  output logic           dout_valid,
  output logic [DIN-1:0] dout_data
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Reject illegal parameterisations while elaborating.
  if (DIN < 1 || DEPTH < int'(MIN_DEPTH) || !is_pow2(DEPTH)) begin : g_param_check
    $error("decouple: DIN must be >= 1 and DEPTH a power of two >= 2");
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // Both handshake outputs depend only on state, never on the other side's inputs.
  assign din_ready  = !full && !rst;
  assign dout_valid = !empty;

  assign push = din_valid && din_ready;
  assign pop  = dout_valid && dout_ready;

  // Advance the pointers on transfers; reset drops all stored words at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  decouple_mem #(
    .DIN    (DIN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (din_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (dout_data)
  );

endmodule

// File: tb/tb_decouple.sv
// Self-checking bench for decouple with DEPTH=4, DIN=8.
module tb_decouple;

  localparam int DIN   = 8;
  localparam int DEPTH = 4;

  logic           clk;
  logic           rst;
  logic           din_ready;
  logic           din_valid;
  logic [DIN-1:0] din_data;
  logic           dout_ready;
  logic           dout_valid;
  logic [DIN-1:0] dout_data;

  int n_tests;
  int n_fail;

  decouple #(.DIN(DIN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_ready  (din_ready),
    .din_valid  (din_valid),
    .din_data   (din_data),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout_data  (dout_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           v;
    logic [DIN-1:0] d;
    logic           r;
    logic           e_rdy;
    logic           e_vld;
    logic [DIN-1:0] e_data;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [DIN-1:0] q [$];
  int sent;
  int got;
  int cyc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // Fill 4 with ready low, 5th held off, then drain in order.
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[5]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h22};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    // Simultaneous push/pop at occupancy 2.
    tbl[11] = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[12] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA0};
    tbl[13] = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA0};
    tbl[14] = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA1};
    tbl[15] = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA2};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

    rst        = 1'b1;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_din_ready", 32'(din_ready), 32'd1);
    chk("rel_dout_valid", 32'(dout_valid), 32'd0);

    // Table vectors: expected values are those seen before each edge.
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      din_valid  = tbl[i].v;
      din_data   = tbl[i].d;
      dout_ready = tbl[i].r;
      @(negedge clk);
      chk($sformatf("vec%0d_din_ready", i), 32'(din_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_dout_valid", i), 32'(dout_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        chk($sformatf("vec%0d_dout_data", i), 32'(dout_data), 32'(tbl[i].e_data));
    end

    // Streaming 0..99 with both sides ready: one cycle latency, no bubbles.
    for (int i = 0; i <= 100; i++) begin
      @(posedge clk);
      #1;
      din_valid  = (i < 100);
      din_data   = 8'(i);
      dout_ready = 1'b1;
      @(negedge clk);
      chk("stream_din_ready", 32'(din_ready), 32'd1);
      chk("stream_dout_valid", 32'(dout_valid), 32'(i > 0));
      if (i > 0) chk("stream_dout_data", 32'(dout_data), 32'(i - 1));
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("stream_empty", 32'(dout_valid), 32'd0);

    // Wrap: 3*DEPTH words with random consumer readiness, scoreboard model.
    sent = 0;
    got  = 0;
    cyc  = 0;
    q.delete();
    while ((sent < 3 * DEPTH || got < 3 * DEPTH) && cyc < 500) begin
      @(posedge clk);
      #1;
      din_valid  = (sent < 3 * DEPTH);
      din_data   = 8'hC0 + 8'(sent);
      dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("wrap_dout_valid", 32'(dout_valid), 32'(q.size() > 0));
      chk("wrap_din_ready", 32'(din_ready), 32'(q.size() < DEPTH));
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) begin
          chk("wrap_spurious_pop", 32'd1, 32'd0);
        end else begin
          chk("wrap_dout_data", 32'(dout_data), 32'(q[0]));
          void'(q.pop_front());
        end
        got++;
      end
      if (din_valid && din_ready) begin
        q.push_back(din_data);
        sent++;
      end
      cyc++;
    end
    chk("wrap_timeout", 32'(cyc < 500), 32'd1);
    chk("wrap_count", 32'(got), 32'(3 * DEPTH));

    // Reset while holding 3 words, asserted mid-cycle.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      din_valid  = 1'b1;
      din_data   = 8'h70 + 8'(i);
      dout_ready = 1'b0;
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("hold3_dout_valid", 32'(dout_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_din_ready", 32'(din_ready), 32'd0);
    chk("midrst_dout_valid", 32'(dout_valid), 32'd0);
    @(negedge clk);
    chk("inrst_din_ready", 32'(din_ready), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    din_valid = 1'b1;
    din_data  = 8'hA5;
    @(negedge clk);
    chk("postrst_din_ready", 32'(din_ready), 32'd1);
    chk("postrst_dout_valid", 32'(dout_valid), 32'd0);
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    chk("postrst_first_valid", 32'(dout_valid), 32'd1);
    chk("postrst_first_data", 32'(dout_data), 32'h0A5);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("postrst_empty", 32'(dout_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
